// File: rtl/tcm_pkg.sv
// tcm_pkg: shared opcodes, ALU codes and FSM states for the two-counter machine sequencer.
package tcm_pkg;
  localparam int INSTR_W = 12;
  localparam logic [2:0] ALU_ZERO  = 3'b000;
  localparam logic [2:0] ALU_INC   = 3'b001;
  localparam logic [2:0] ALU_DEC   = 3'b010;
  localparam logic [2:0] ALU_PASSA = 3'b011;
  localparam logic [2:0] ALU_PASSB = 3'b100;
  localparam logic [2:0] ALU_SUB   = 3'b101;
  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_INC  = 3'b001;
  localparam logic [2:0] OP_DEC  = 3'b010;
  localparam logic [2:0] OP_JZ   = 3'b011;
  localparam logic [2:0] OP_JMP  = 3'b100;
  localparam logic [2:0] OP_CLR  = 3'b101;
  localparam logic [2:0] OP_HALT = 3'b110;
  localparam logic [2:0] OP_ILL  = 3'b111;
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALTED} state_e;
endpackage

// File: rtl/tcm_decode.sv
// tcm_decode: combinational instruction decode into ALU opcode and writeback/branch controls.
module tcm_decode
  import tcm_pkg::*;
(
  input  logic [2:0] op,
  input  logic       sel,
  input  logic       c0_zero,
  input  logic       c1_zero,
  output logic [2:0] alu_op,
  output logic       wr_en,
  output logic       wr_sel,
  output logic       jump,
  output logic       halt,
  output logic       illegal
);
  logic x_zero;
  logic dec_ok;
  always_comb begin
    x_zero  = sel ? c1_zero : c0_zero;
    // DEC of a zero counter degrades to a pass so the counter never wraps below 0
    dec_ok  = (op == OP_DEC) && !x_zero;
    alu_op  = (op == OP_INC) ? ALU_INC : dec_ok ? ALU_DEC : (op == OP_CLR) ? ALU_ZERO : ALU_PASSA;
    wr_en   = (op == OP_INC) || dec_ok || (op == OP_CLR);
    wr_sel  = sel;
    jump    = (op == OP_JMP) || ((op == OP_JZ) && x_zero);
    halt    = op == OP_HALT;
    illegal = op == OP_ILL;
  end
endmodule

// File: rtl/tcm_controller.sv
// tcm_controller: fetch/execute sequencer for the two-counter machine.
// Optional step-limit timeout and step_count port enabled by TCM_STEP_LIMIT_EN.
module tcm_controller
  import tcm_pkg::*;
#(
  parameter int PC_W = 8
`ifdef TCM_STEP_LIMIT_EN
  , parameter int STEP_LIMIT = 255
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [7:0]         init_c0,
  input  logic [7:0]         init_c1,
  output logic               imem_en,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [2:0]         alu_op,
  output logic [7:0]         alu_a,
  output logic [7:0]         alu_b,
  input  logic [7:0]         alu_result,
  output logic [7:0]         c0_out,
  output logic [7:0]         c1_out,
  output logic               busy,
  output logic               done,
  output logic               err,
`ifdef TCM_STEP_LIMIT_EN
  output logic [7:0]         step_count,
`endif
  output logic               ovf
);
  state_e state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0] c0_q, c0_d, c1_q, c1_d;
  logic err_q, err_d, ovf_q, ovf_d;
  logic [2:0] dec_op;
  logic wr_en, wr_sel, jump, halt, illegal;
`ifdef TCM_STEP_LIMIT_EN
  logic [7:0] step_q, step_d;
  assign step_count = step_q;
`endif
  tcm_decode u_decode (
    .op(imem_data[11:9]), .sel(imem_data[8]),
    .c0_zero(c0_q == 8'd0), .c1_zero(c1_q == 8'd0),
    .alu_op(dec_op), .wr_en(wr_en), .wr_sel(wr_sel),
    .jump(jump), .halt(halt), .illegal(illegal)
  );
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    c0_d    = c0_q;
    c1_d    = c1_q;
    err_d   = err_q;
    ovf_d   = ovf_q;
`ifdef TCM_STEP_LIMIT_EN
    step_d  = step_q;
`endif
    unique case (state_q)
      IDLE, HALTED: if (start) begin
        state_d = FETCH;
        pc_d    = '0;
        c0_d    = init_c0;
        c1_d    = init_c1;
        err_d   = 1'b0;
        ovf_d   = 1'b0;
`ifdef TCM_STEP_LIMIT_EN
        step_d  = 8'd0;
`endif
      end
      FETCH: state_d = EXEC;
      EXEC: begin
        state_d = (halt || illegal) ? HALTED : FETCH;
        pc_d    = jump ? PC_W'(imem_data[7:0]) : (halt || illegal) ? pc_q : pc_q + PC_W'(1);
        c0_d    = (wr_en && !wr_sel) ? alu_result : c0_q;
        c1_d    = (wr_en && wr_sel) ? alu_result : c1_q;
        err_d   = err_q || illegal;
        ovf_d   = ovf_q || ((imem_data[11:9] == OP_INC) && (alu_result == 8'd0));
`ifdef TCM_STEP_LIMIT_EN
        step_d  = step_q + 8'd1;
        // the instruction still commits; the limit only overrides where the FSM goes next
        if (step_d == 8'(STEP_LIMIT)) begin
          state_d = HALTED;
          err_d   = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      c0_q    <= 8'd0;
      c1_q    <= 8'd0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef TCM_STEP_LIMIT_EN
      step_q  <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      c0_q    <= c0_d;
      c1_q    <= c1_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
`ifdef TCM_STEP_LIMIT_EN
      step_q  <= step_d;
`endif
    end
  end
  // IDLE presents the all-zero reset opcode; FETCH and HALTED idle the ALU on pass-A
  assign alu_op    = (state_q == EXEC) ? dec_op : (state_q == IDLE) ? ALU_ZERO : ALU_PASSA;
  assign alu_a     = imem_data[8] ? c1_q : c0_q;
  assign alu_b     = imem_data[8] ? c0_q : c1_q;
  assign imem_en   = state_q == FETCH;
  assign imem_addr = pc_q;
  assign busy      = (state_q == FETCH) || (state_q == EXEC);
  assign done      = state_q == HALTED;
  assign c0_out    = c0_q;
  assign c1_out    = c1_q;
  assign err       = err_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_tcm_controller.sv
// tb_tcm_controller: directed programs against an instruction memory and ALU model.
module tb_tcm_controller;
  logic        clk = 1'b0;
  logic        rst, start;
  logic [7:0]  init_c0, init_c1;
  logic        imem_en;
  logic [7:0]  imem_addr;
  logic [11:0] imem_data;
  logic [2:0]  alu_op;
  logic [7:0]  alu_a, alu_b, alu_result;
  logic [7:0]  c0_out, c1_out;
  logic        busy, done, err, ovf;
`ifdef TCM_STEP_LIMIT_EN
  logic [7:0]  step_count;
`endif
  logic [11:0] mem [256];
  int n_vec = 0;
  int n_err = 0;

  tcm_controller dut (
    .clk(clk), .rst(rst), .start(start), .init_c0(init_c0), .init_c1(init_c1),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_data(imem_data),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .c0_out(c0_out), .c1_out(c1_out), .busy(busy), .done(done), .err(err),
`ifdef TCM_STEP_LIMIT_EN
    .step_count(step_count),
`endif
    .ovf(ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (imem_en) imem_data <= mem[imem_addr];

  always_comb begin
    alu_result = 8'd0;
    case (alu_op)
      3'b001: alu_result = alu_a + 8'd1;
      3'b010: alu_result = alu_a - 8'd1;
      3'b011: alu_result = alu_a;
      3'b100: alu_result = alu_b;
      3'b101: alu_result = alu_a - alu_b;
      default: alu_result = 8'd0;
    endcase
  end

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 12'hC00;
  endtask

  task automatic go(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    init_c0 = a;
    init_c1 = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(tag, int'(done), 1);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b1;
    init_c0 = 8'd7;
    init_c1 = 8'd9;
    imem_data = 12'h000;
    clear_mem();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    // 1: reset state, start ignored while rst
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_imem_en", int'(imem_en), 0);
    check("rst_addr", int'(imem_addr), 0);
    check("rst_c0", int'(c0_out), 0);
    check("rst_c1", int'(c1_out), 0);
    check("rst_err", int'(err), 0);
    check("rst_ovf", int'(ovf), 0);
    check("rst_alu_op", int'(alu_op), 0);

    // 2: INC C0; DEC C1; HALT with exact latency
    clear_mem();
    mem[0] = 12'h200;
    mem[1] = 12'h500;
    mem[2] = 12'hC00;
    go(8'd3, 8'd0);
    check("t2_fetch_en", int'(imem_en), 1);
    check("t2_fetch_alu", int'(alu_op), 3);
    check("t2_busy", int'(busy), 1);
    repeat (4) @(negedge clk);
    check("t2_dec0_alu", int'(alu_op), 3);
    @(negedge clk);
    check("t2_done_early", int'(done), 0);
    @(negedge clk);
    check("t2_done", int'(done), 1);
    check("t2_c0", int'(c0_out), 4);
    check("t2_c1", int'(c1_out), 0);
    check("t2_halt_pc", int'(imem_addr), 2);
    check("t2_busy_off", int'(busy), 0);

    // 3: INC wraps and sets ovf
    clear_mem();
    mem[0] = 12'h200;
    go(8'd255, 8'd17);
    wait_done("t3_done");
    check("t3_c0", int'(c0_out), 0);
    check("t3_c1", int'(c1_out), 17);
    check("t3_ovf", int'(ovf), 1);
    check("t3_err", int'(err), 0);

    // 4: countdown loop JZ/DEC/JMP
    clear_mem();
    mem[0] = 12'h603;
    mem[1] = 12'h400;
    mem[2] = 12'h800;
    go(8'd2, 8'd0);
    check("t4_ovf_clr", int'(ovf), 0);
    wait_done("t4_done");
    check("t4_c0", int'(c0_out), 0);
    check("t4_c1", int'(c1_out), 0);
    check("t4_pc", int'(imem_addr), 3);

    // 5: illegal op, then restart clears err
    clear_mem();
    mem[0] = 12'hE00;
    go(8'd5, 8'd6);
    wait_done("t5_done");
    check("t5_err", int'(err), 1);
    check("t5_c0", int'(c0_out), 5);
    check("t5_c1", int'(c1_out), 6);
    check("t5_pc", int'(imem_addr), 0);
    mem[0] = 12'hD00;
    go(8'd1, 8'd2);
    check("t5_err_clr", int'(err), 0);
    wait_done("t5_done2");
    check("t5_c1_keep", int'(c1_out), 2);

    // CLR C1 and JZ taken on C1 with a target that is not pc+1
    clear_mem();
    mem[0] = 12'hB00;
    mem[1] = 12'h7F0;
    mem[240] = 12'h200;
    go(8'd10, 8'd44);
    wait_done("t7_done");
    check("t7_c1", int'(c1_out), 0);
    check("t7_c0", int'(c0_out), 11);
    check("t7_pc", int'(imem_addr), 241);

    // 6: reset during EXEC of INC discards the write
    clear_mem();
    mem[0] = 12'h200;
    go(8'd9, 8'd4);
    @(negedge clk);
    check("t6_exec_alu", int'(alu_op), 1);
    check("t6_exec_a", int'(alu_a), 9);
    check("t6_exec_b", int'(alu_b), 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_busy", int'(busy), 0);
    check("t6_done", int'(done), 0);
    check("t6_c0", int'(c0_out), 0);
    check("t6_alu_op", int'(alu_op), 0);
    @(negedge clk);
    check("t6_idle", int'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
